cart_bank_mapper: RTL and testbench

Parametrised successor to the fixed-layout cartridge banking logic. Splits the 6502 64 KB space into `NUM_WIN` equal windows; loader-programmable type and initial bank per window; runtime-writable per-window bank registers through a hotspot range, with a lock bit. Performs ROM fetches to SDRAM through a req/ack handshake with a one-entry read cache, and hosts banked cart RAM. Sits between the CPU bus and the SDRAM/ROM port, alongside the audio chips in the cart top level.

---
 rtl/cart_pkg.sv | 25 ++
 rtl/cart_bank_mapper_if.sv | 29 ++
 rtl/cart_bank_mapper_spram.sv | 25 ++
 rtl/cart_bank_mapper.sv | 183 ++++++++++++++++++
 tb/tb_cart_bank_mapper.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge bank mapper.
// Window types match the loader's 2-bit cfg_type encoding.
package cart_pkg;

    typedef enum logic [1:0] {
        WIN_OPEN   = 2'd0,
        WIN_FIXED  = 2'd1,
        WIN_BANKED = 2'd2,
        WIN_RAM    = 2'd3
    } win_type_e;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [15:0] HOT_BASE_DEFAULT = 16'hFFE0;
    localparam int          ROM_AW           = 25;

    function automatic logic is_rom(input win_type_e t);
        return (t == WIN_FIXED) || (t == WIN_BANKED);
    endfunction

endpackage

// File: rtl/cart_bank_mapper_if.sv
// CPU bus plus SDRAM read handshake seen by the mapper.
// master = CPU/SDRAM environment, slave = the mapper.
interface cart_bus_if;
    import cart_pkg::*;

    logic              pclk0;
    logic [15:0]       address_in;
    logic [7:0]        din;
    logic              rw;
    logic              cart_cs;
    logic [7:0]        open_bus;
    logic [7:0]        dout;
    logic              dout_valid;
    logic              rom_req;
    logic [ROM_AW-1:0] rom_address;
    logic              rom_ack;
    logic [7:0]        rom_din;

    modport master (
        output pclk0, address_in, din, rw, cart_cs, open_bus, rom_ack, rom_din,
        input  dout, dout_valid, rom_req, rom_address
    );

    modport slave (
        input  pclk0, address_in, din, rw, cart_cs, open_bus, rom_ack, rom_din,
        output dout, dout_valid, rom_req, rom_address
    );

endinterface

// File: rtl/cart_bank_mapper_spram.sv
// Single-port cart RAM with a registered, write-first read port.
module spram #(
    parameter int addr_width = 15,
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] addr,
    input  logic [data_width-1:0] d,
    output logic [data_width-1:0] q
);

    logic [data_width-1:0] mem [2**addr_width];

    // Write-first so a read of the address just written returns the new byte.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= d;
            q         <= d;
        end else begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/cart_bank_mapper.sv
// Windowed cartridge banking: per-window type/bank tables, hotspot bank writes
// with lock, cached SDRAM ROM fetches and banked cart RAM.
module cart_bank_mapper
    import cart_pkg::*;
#(
    parameter int          NUM_WIN  = 8,
    parameter int          BANK_W   = 8,
    parameter int          RAM_AW   = 15,
    parameter logic [15:0] HOT_BASE = HOT_BASE_DEFAULT
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    cart_bus_if.slave                  bus,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_WIN)-1:0] cfg_idx,
    input  logic [1:0]                 cfg_type,
    input  logic [BANK_W-1:0]          cfg_bank,
    input  logic [BANK_W-1:0]          bank_mask,
    output logic                       locked
);

    localparam int          WIN_BITS  = $clog2(NUM_WIN);
    localparam int          WIN_AW    = 16 - WIN_BITS;
    localparam int          FULL_AW   = BANK_W + WIN_AW;
    localparam logic [15:0] LOCK_ADDR = 16'(HOT_BASE + NUM_WIN);

    win_type_e           win_type  [NUM_WIN];
    logic [BANK_W-1:0]   bank_init [NUM_WIN];
    logic [BANK_W-1:0]   bank_reg  [NUM_WIN];

    fetch_state_e        state, state_next;
    logic                cache_valid;
    logic [15:0]         tag_addr, req_addr;
    logic [BANK_W-1:0]   tag_bank, req_bank;
    logic [7:0]          cache_data;

    logic [WIN_BITS-1:0] win;
    logic [WIN_AW-1:0]   offset;
    win_type_e           cur_type;
    logic [BANK_W-1:0]   eff_bank, masked_bank;
    logic                cpu_wr, hot_hit, lock_we, invalidate;
    logic [NUM_WIN-1:0]  hot_bank_we;
    logic                tag_hit, miss;

    logic [FULL_AW-1:0]  ram_full;
    logic [RAM_AW-1:0]   ram_addr, ram_addr_q;
    logic                ram_we;
    logic [7:0]          ram_q;

    assign win         = bus.address_in[15:WIN_AW];
    assign offset      = bus.address_in[WIN_AW-1:0];
    assign cur_type    = win_type[win];
    assign eff_bank    = (cur_type == WIN_FIXED) ? bank_init[win] : bank_reg[win];
    assign masked_bank = eff_bank & bank_mask;

    assign cpu_wr  = bus.cart_cs & ~bus.rw & bus.pclk0;
    assign hot_hit = (bus.address_in >= HOT_BASE) && (bus.address_in <= LOCK_ADDR);
    assign lock_we = cpu_wr && (bus.address_in == LOCK_ADDR) && bus.din[7];

    always_comb begin
        hot_bank_we = '0;
        for (int k = 0; k < NUM_WIN; k++) begin
            if (cpu_wr && (bus.address_in == 16'(HOT_BASE + k)) && !locked &&
                (win_type[k] == WIN_BANKED)) begin
                hot_bank_we[k] = 1'b1;
            end
        end
    end

    assign invalidate = cfg_we | (|hot_bank_we);

    // Loader tables survive reset; only the live bank registers are reloaded.
    always_ff @(posedge clk_sys) begin
        if (cfg_we) begin
            win_type[cfg_idx]  <= win_type_e'(cfg_type);
            bank_init[cfg_idx] <= cfg_bank;
        end
    end

    // The loader write comes last so it overrides a same-cycle hotspot write.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int k = 0; k < NUM_WIN; k++) bank_reg[k] <= bank_init[k];
        end else begin
            for (int k = 0; k < NUM_WIN; k++) begin
                if (hot_bank_we[k]) bank_reg[k] <= BANK_W'(bus.din);
            end
            if (cfg_we) bank_reg[cfg_idx] <= cfg_bank;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset)        locked <= 1'b0;
        else if (lock_we) locked <= 1'b1;
    end

    assign tag_hit = cache_valid && (tag_addr == bus.address_in) && (tag_bank == masked_bank);
    assign miss    = bus.cart_cs && bus.rw && is_rom(cur_type) && !tag_hit;

    always_comb begin
        state_next = state;
        case (state)
            FETCH_IDLE: if (miss) state_next = FETCH_REQ;
            FETCH_REQ:  if (bus.rom_ack) state_next = FETCH_HOLD;
            FETCH_HOLD: state_next = FETCH_IDLE;
            default:    state_next = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) state <= FETCH_IDLE;
        else       state <= state_next;
    end

    // The request tag is frozen at issue so a mid-fetch address change caches
    // the stale byte under its own tag rather than the new address.
    always_ff @(posedge clk_sys) begin
        if (state == FETCH_IDLE && miss) begin
            req_addr <= bus.address_in;
            req_bank <= masked_bank;
        end
        if (state == FETCH_REQ && bus.rom_ack) begin
            tag_addr   <= req_addr;
            tag_bank   <= req_bank;
            cache_data <= bus.rom_din;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cache_valid <= 1'b0;
        end else if (invalidate) begin
            cache_valid <= 1'b0;
        end else if (state == FETCH_REQ && bus.rom_ack) begin
            cache_valid <= 1'b1;
        end
    end

    assign bus.rom_req     = (state == FETCH_REQ);
    assign bus.rom_address = (state == FETCH_REQ) ? ROM_AW'({req_bank, req_addr[WIN_AW-1:0]})
                                                  : ROM_AW'({masked_bank, offset});

    assign ram_full = {bank_reg[win], offset};
    assign ram_addr = ram_full[RAM_AW-1:0];
    assign ram_we   = cpu_wr && (cur_type == WIN_RAM) && !hot_hit;

    spram #(
        .addr_width (RAM_AW),
        .data_width (8)
    ) u_ram (
        .clk  (clk_sys),
        .we   (ram_we),
        .addr (ram_addr),
        .d    (bus.din),
        .q    (ram_q)
    );

    always_ff @(posedge clk_sys) begin
        ram_addr_q <= ram_addr;
    end

    always_comb begin
        bus.dout       = bus.open_bus;
        bus.dout_valid = 1'b1;
        if (bus.cart_cs) begin
            case (cur_type)
                WIN_FIXED, WIN_BANKED: begin
                    bus.dout       = cache_data;
                    bus.dout_valid = tag_hit;
                end
                WIN_RAM: begin
                    bus.dout       = ram_q;
                    bus.dout_valid = (ram_addr == ram_addr_q);
                end
                default: begin
                    bus.dout       = bus.open_bus;
                    bus.dout_valid = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_bank_mapper.sv
// Scenario-driven bench for cart_bank_mapper with an expected-value queue.
module tb_cart_bank_mapper;
    import cart_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [1:0] cfg_type;
    logic [7:0] cfg_bank;
    logic [7:0] bank_mask;
    logic       locked;

    int n_vec = 0;
    int n_err = 0;
    logic [24:0] exp_q[$];
    logic [24:0] exp;
    bit seen;

    cart_bus_if bus ();

    cart_bank_mapper dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .bus       (bus),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_type  (cfg_type),
        .cfg_bank  (cfg_bank),
        .bank_mask (bank_mask),
        .locked    (locked)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [24:0] exp_rom(input logic [7:0] bank, input logic [7:0] mask,
                                            input logic [15:0] addr);
        return {4'b0, bank & mask, addr[12:0]};
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rom_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_ack(input logic [7:0] data);
        bus.rom_ack = 1'b1;
        bus.rom_din = data;
        tick();
        bus.rom_ack = 1'b0;
        bus.rom_din = 8'h00;
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [1:0] t, input logic [7:0] b);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_type = t;
        cfg_bank = b;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic hot_write(input logic [15:0] addr, input logic [7:0] data);
        bus.address_in = addr;
        bus.din        = data;
        bus.rw         = 1'b0;
        bus.cart_cs    = 1'b1;
        bus.pclk0      = 1'b1;
        tick();
        bus.pclk0   = 1'b0;
        bus.rw      = 1'b1;
        bus.cart_cs = 1'b0;
    endtask

    task automatic test_reset();
        cfg_write(3'd0, 2'd0, 8'h00);
        cfg_write(3'd1, 2'd0, 8'h00);
        cfg_write(3'd2, 2'd3, 8'h01);
        cfg_write(3'd3, 2'd0, 8'h00);
        cfg_write(3'd4, 2'd2, 8'h00);
        cfg_write(3'd5, 2'd0, 8'h00);
        cfg_write(3'd6, 2'd0, 8'h00);
        cfg_write(3'd7, 2'd1, 8'h03);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_vec++;
        if (bus.rom_req !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rom_req: got %b required 0", bus.rom_req); end
        n_vec++;
        if (locked !== 1'b0) begin n_err++; $display("[TB] FAIL reset_locked: got %b required 0", locked); end
        bus.address_in = 16'hE123;
        bus.cart_cs    = 1'b0;
        bus.rw         = 1'b1;
        #1;
        n_vec++;
        if (bus.dout !== 8'h5A || bus.dout_valid !== 1'b1) begin
            n_err++; $display("[TB] FAIL deselected_read: got %h/%b required 5a/1", bus.dout, bus.dout_valid);
        end
        bus.address_in = 16'h2000;
        bus.cart_cs    = 1'b1;
        #1;
        n_vec++;
        if (bus.dout !== 8'h5A || bus.dout_valid !== 1'b1) begin
            n_err++; $display("[TB] FAIL open_window_read: got %h/%b required 5a/1", bus.dout, bus.dout_valid);
        end
        bus.address_in = 16'hE123;
        #1;
        n_vec++;
        if (bus.dout_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rom_valid: got %b required 0", bus.dout_valid); end
    endtask

    task automatic test_fixed_rom();
        int held;
        int extra;
        exp_q.push_back(exp_rom(8'h03, 8'hFF, 16'hE123));
        wait_req(seen);
        n_vec++;
        if (!seen) begin n_err++; $display("[TB] FAIL fixed_req_timeout: got no rom_req required rom_req"); end
        exp = exp_q.pop_front();
        n_vec++;
        if (bus.rom_address !== exp) begin n_err++; $display("[TB] FAIL fixed_rom_address: got %h required %h", bus.rom_address, exp); end
        held = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.rom_req === 1'b1 && bus.rom_address === exp) held++;
        end
        n_vec++;
        if (held != 2) begin n_err++; $display("[TB] FAIL fixed_req_hold: got %0d required 2", held); end
        exp_q.push_back(25'h0A5);
        pulse_ack(8'hA5);
        exp = exp_q.pop_front();
        n_vec++;
        if (bus.rom_req !== 1'b0) begin n_err++; $display("[TB] FAIL fixed_req_drop: got %b required 0", bus.rom_req); end
        n_vec++;
        if (bus.dout !== exp[7:0] || bus.dout_valid !== 1'b1) begin
            n_err++; $display("[TB] FAIL fixed_data: got %h/%b required %h/1", bus.dout, bus.dout_valid, exp[7:0]);
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.rom_req !== 1'b0) extra++;
        end
        n_vec++;
        if (extra != 0 || bus.dout_valid !== 1'b1) begin
            n_err++; $display("[TB] FAIL fixed_cache_hit: got %0d reqs valid %b required 0 reqs valid 1", extra, bus.dout_valid);
        end
        bus.cart_cs = 1'b0;
    endtask

    task automatic test_banked_rom();
        hot_write(16'hFFE4, 8'h05);
        bus.address_in = 16'h8010;
        bus.rw         = 1'b1;
        bus.cart_cs    = 1'b1;
        exp_q.push_back(exp_rom(8'h05, 8'hFF, 16'h8010));
        wait_req(seen);
        n_vec++;
        if (!seen) begin n_err++; $display("[TB] FAIL banked_req_timeout: got no rom_req required rom_req"); end
        exp = exp_q.pop_front();
        n_vec++;
        if (bus.rom_address !== exp) begin n_err++; $display("[TB] FAIL banked_rom_address: got %h required %h", bus.rom_address, exp); end
        bank_mask = 8'h03;
        #1;
        n_vec++;
        if (bus.rom_address !== exp) begin n_err++; $display("[TB] FAIL banked_latched_address: got %h required %h", bus.rom_address, exp); end
        pulse_ack(8'h11);
        n_vec++;
        if (bus.dout_valid !== 1'b0) begin n_err++; $display("[TB] FAIL masked_stale_valid: got %b required 0", bus.dout_valid); end
        exp_q.push_back(exp_rom(8'h05, 8'h03, 16'h8010));
        wait_req(seen);
        n_vec++;
        if (!seen) begin n_err++; $display("[TB] FAIL masked_req_timeout: got no rom_req required rom_req"); end
        exp = exp_q.pop_front();
        n_vec++;
        if (bus.rom_address !== exp) begin n_err++; $display("[TB] FAIL masked_rom_address: got %h required %h", bus.rom_address, exp); end
        exp_q.push_back(25'h022);
        pulse_ack(8'h22);
        exp = exp_q.pop_front();
        n_vec++;
        if (bus.dout !== exp[7:0] || bus.dout_valid !== 1'b1) begin
            n_err++; $display("[TB] FAIL masked_data: got %h/%b required %h/1", bus.dout, bus.dout_valid, exp[7:0]);
        end
        bus.cart_cs = 1'b0;
        bank_mask   = 8'hFF;
        tick();
    endtask

    task automatic test_cfg_priority();
        cfg_we         = 1'b1;
        cfg_idx        = 3'd4;
        cfg_type       = 2'd2;
        cfg_bank       = 8'h07;
        bus.address_in = 16'hFFE4;
        bus.din        = 8'h09;
        bus.rw         = 1'b0;
        bus.cart_cs    = 1'b1;
        bus.pclk0      = 1'b1;
        tick();
        cfg_we         = 1'b0;
        bus.pclk0      = 1'b0;
        bus.rw         = 1'b1;
        bus.cart_cs    = 1'b0;
        bus.address_in = 16'h8010;
        #1;
        n_vec++;
        if (bus.rom_address !== exp_rom(8'h07, 8'hFF, 16'h8010)) begin
            n_err++; $display("[TB] FAIL cfg_wins: got %h required %h", bus.rom_address, exp_rom(8'h07, 8'hFF, 16'h8010));
        end
    endtask

    task automatic test_lock();
        hot_write(16'hFFE8, 8'h7F);
        n_vec++;
        if (locked !== 1'b0) begin n_err++; $display("[TB] FAIL lock_bit7_clear: got %b required 0", locked); end
        hot_write(16'hFFE4, 8'h05);
        bus.address_in = 16'h8010;
        #1;
        n_vec++;
        if (bus.rom_address !== exp_rom(8'h05, 8'hFF, 16'h8010)) begin
            n_err++; $display("[TB] FAIL unlocked_bank_write: got %h required %h", bus.rom_address, exp_rom(8'h05, 8'hFF, 16'h8010));
        end
        hot_write(16'hFFE8, 8'h80);
        n_vec++;
        if (locked !== 1'b1) begin n_err++; $display("[TB] FAIL lock_set: got %b required 1", locked); end
        hot_write(16'hFFE4, 8'h02);
        bus.address_in = 16'h8010;
        #1;
        n_vec++;
        if (bus.rom_address !== exp_rom(8'h05, 8'hFF, 16'h8010)) begin
            n_err++; $display("[TB] FAIL locked_bank_write: got %h required %h", bus.rom_address, exp_rom(8'h05, 8'hFF, 16'h8010));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_vec++;
        if (locked !== 1'b0) begin n_err++; $display("[TB] FAIL lock_reset: got %b required 0", locked); end
        n_vec++;
        if (bus.rom_address !== exp_rom(8'h07, 8'hFF, 16'h8010)) begin
            n_err++; $display("[TB] FAIL bank_reset_init: got %h required %h", bus.rom_address, exp_rom(8'h07, 8'hFF, 16'h8010));
        end
    endtask

    task automatic test_ram();
        bus.address_in = 16'h4005;
        bus.din        = 8'h3C;
        bus.rw         = 1'b0;
        bus.cart_cs    = 1'b1;
        bus.pclk0      = 1'b1;
        tick();
        bus.pclk0 = 1'b0;
        cfg_write(3'd2, 2'd3, 8'h00);
        bus.din   = 8'hC3;
        bus.pclk0 = 1'b1;
        tick();
        bus.pclk0 = 1'b0;
        bus.rw    = 1'b1;
        exp_q.push_back(25'h0C3);
        tick();
        exp = exp_q.pop_front();
        n_vec++;
        if (bus.dout !== exp[7:0] || bus.dout_valid !== 1'b1) begin
            n_err++; $display("[TB] FAIL ram_bank0_read: got %h/%b required %h/1", bus.dout, bus.dout_valid, exp[7:0]);
        end
        cfg_write(3'd2, 2'd3, 8'h01);
        n_vec++;
        if (bus.dout_valid !== 1'b0) begin n_err++; $display("[TB] FAIL ram_settle_valid: got %b required 0", bus.dout_valid); end
        exp_q.push_back(25'h03C);
        tick();
        exp = exp_q.pop_front();
        n_vec++;
        if (bus.dout !== exp[7:0] || bus.dout_valid !== 1'b1) begin
            n_err++; $display("[TB] FAIL ram_bank1_read: got %h/%b required %h/1", bus.dout, bus.dout_valid, exp[7:0]);
        end
        bus.din = 8'hFF;
        bus.rw  = 1'b0;
        tick();
        bus.rw = 1'b1;
        tick();
        n_vec++;
        if (bus.dout !== 8'h3C) begin n_err++; $display("[TB] FAIL ram_no_strobe_write: got %h required 3c", bus.dout); end
        bus.cart_cs = 1'b0;
    endtask

    task automatic test_stale();
        bus.address_in = 16'hE000;
        bus.rw         = 1'b1;
        bus.cart_cs    = 1'b1;
        exp_q.push_back(exp_rom(8'h03, 8'hFF, 16'hE000));
        wait_req(seen);
        n_vec++;
        if (!seen) begin n_err++; $display("[TB] FAIL stale_req_timeout: got no rom_req required rom_req"); end
        exp = exp_q.pop_front();
        bus.address_in = 16'hE001;
        #1;
        n_vec++;
        if (bus.rom_address !== exp) begin n_err++; $display("[TB] FAIL stale_latched_address: got %h required %h", bus.rom_address, exp); end
        pulse_ack(8'h77);
        n_vec++;
        if (bus.dout_valid !== 1'b0) begin n_err++; $display("[TB] FAIL stale_valid: got %b required 0", bus.dout_valid); end
        bus.address_in = 16'hE000;
        #1;
        n_vec++;
        if (bus.dout !== 8'h77 || bus.dout_valid !== 1'b1) begin
            n_err++; $display("[TB] FAIL stale_tag: got %h/%b required 77/1", bus.dout, bus.dout_valid);
        end
        bus.address_in = 16'hE001;
        exp_q.push_back(exp_rom(8'h03, 8'hFF, 16'hE001));
        wait_req(seen);
        n_vec++;
        if (!seen) begin n_err++; $display("[TB] FAIL refetch_timeout: got no rom_req required rom_req"); end
        exp = exp_q.pop_front();
        n_vec++;
        if (bus.rom_address !== exp) begin n_err++; $display("[TB] FAIL refetch_address: got %h required %h", bus.rom_address, exp); end
        exp_q.push_back(25'h078);
        pulse_ack(8'h78);
        exp = exp_q.pop_front();
        n_vec++;
        if (bus.dout !== exp[7:0] || bus.dout_valid !== 1'b1) begin
            n_err++; $display("[TB] FAIL refetch_data: got %h/%b required %h/1", bus.dout, bus.dout_valid, exp[7:0]);
        end
        bus.cart_cs = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_req();
        bus.address_in = 16'hE100;
        bus.rw         = 1'b1;
        bus.cart_cs    = 1'b1;
        exp_q.push_back(exp_rom(8'h03, 8'hFF, 16'hE100));
        wait_req(seen);
        n_vec++;
        if (!seen) begin n_err++; $display("[TB] FAIL midreq_timeout: got no rom_req required rom_req"); end
        exp = exp_q.pop_front();
        n_vec++;
        if (bus.rom_address !== exp) begin n_err++; $display("[TB] FAIL midreq_address: got %h required %h", bus.rom_address, exp); end
        reset       = 1'b1;
        bus.cart_cs = 1'b0;
        tick();
        n_vec++;
        if (bus.rom_req !== 1'b0) begin n_err++; $display("[TB] FAIL midreq_drop: got %b required 0", bus.rom_req); end
        reset = 1'b0;
        tick();
        pulse_ack(8'hEE);
        tick();
        bus.cart_cs = 1'b1;
        #1;
        n_vec++;
        if (bus.dout_valid !== 1'b0 || bus.rom_req !== 1'b0) begin
            n_err++; $display("[TB] FAIL stray_ack: got valid %b req %b required 0/0", bus.dout_valid, bus.rom_req);
        end
        bus.cart_cs = 1'b0;
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        cfg_we         = 1'b0;
        cfg_idx        = '0;
        cfg_type       = '0;
        cfg_bank       = '0;
        bank_mask      = 8'hFF;
        bus.pclk0      = 1'b0;
        bus.address_in = 16'h0000;
        bus.din        = 8'h00;
        bus.rw         = 1'b1;
        bus.cart_cs    = 1'b0;
        bus.open_bus   = 8'h5A;
        bus.rom_ack    = 1'b0;
        bus.rom_din    = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        $display("[TB] starting scenarios");
        test_reset();
        test_fixed_rom();
        test_banked_rom();
        test_cfg_priority();
        test_lock();
        test_ram();
        test_stale();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
